// File: rtl/load_store_ctrl.sv
// Load/store controller: turns one core load/store request into one or two word-aligned
// memory transactions, handling byte lanes and sign/zero extension.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   start, is_store   request strobe (sampled only while idle) and direction
//   funct3            RISC-V size code (b, h, w, bu, hu)
//   addr, wdata       byte address and right-justified store data
//   busy, done, err   status: busy outside idle, one-cycle done pulse, error with done
//   rdata             extended load result, held until the next accepted request
//   mem_req, mem_we   memory request valid and write enable
//   mem_addr, mem_be  word-aligned address and byte-lane enables
//   mem_wdata         lane-aligned store data
//   mem_ack           memory completes the current request this cycle
//   mem_rdata         read word, valid with mem_ack
module load_store_ctrl #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_e;

    state_e      state_q, state_d;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] word0_q, word0_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept, req_illegal, split_q;
    logic [1:0]  off_q;
    logic [31:0] word_addr;
    logic [7:0]  be_cat;
    logic [63:0] st_cat;
    logic [31:0] ld_lo, ld_hi, ld_shift, load_result;
    logic [63:0] ld_cat;

    // Size code 2'b11 is illegal and never reaches an access; treat it as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] code);
        case (code)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] code, input logic [1:0] off);
        return ({1'b0, off} + size_bytes(code)) > 3'd4;
    endfunction

    assign accept = (state_q == StIdle) && start;

    assign req_illegal = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1])
                       || (is_store && funct3[2])
                       || (!ALLOW_MISALIGN && crosses_word(funct3[1:0], addr[1:0]));

    assign off_q     = addr_q[1:0];
    assign split_q   = crosses_word(funct3_q[1:0], off_q);
    assign word_addr = {addr_q[31:2], 2'b00};

    // Lane placement over two words; the high word only matters for split accesses.
    always_comb begin
        logic [3:0] m;
        m      = size_mask(funct3_q[1:0]);
        be_cat = {4'b0000, m} << off_q;
        st_cat = {32'b0, wdata_q & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}}}
                 << {off_q, 3'b000};
    end

    // Load result is formed in the cycle of the final ack, straight from mem_rdata.
    always_comb begin
        ld_lo    = (state_q == StAcc1) ? word0_q : mem_rdata;
        ld_hi    = (state_q == StAcc1) ? mem_rdata : 32'b0;
        ld_cat   = {ld_hi, ld_lo};
        ld_shift = ld_cat[{off_q, 3'b000} +: 32];
        case (funct3_q)
            3'b000:  load_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  load_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  load_result = {24'b0, ld_shift[7:0]};
            3'b101:  load_result = {16'b0, ld_shift[15:0]};
            default: load_result = ld_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word0_d = word0_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (req_illegal) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = 32'b0;
                    end else begin
                        state_d = StAcc0;
                        err_d   = 1'b0;
                    end
                end
            end
            StAcc0: begin
                if (mem_ack) begin
                    word0_d = mem_rdata;
                    if (split_q) begin
                        state_d = StAcc1;
                    end else begin
                        state_d = StDone;
                        if (!is_store_q) rdata_d = load_result;
                    end
                end
            end
            StAcc1: begin
                if (mem_ack) begin
                    state_d = StDone;
                    if (!is_store_q) rdata_d = load_result;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_be    = 4'b0;
        mem_wdata = 32'b0;
        unique case (state_q)
            StAcc0: begin
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = word_addr;
                mem_be    = be_cat[3:0];
                mem_wdata = st_cat[31:0];
            end
            StAcc1: begin
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = word_addr + 32'd4;
                mem_be    = be_cat[7:4];
                mem_wdata = st_cat[63:32];
            end
            StDone: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            word0_q    <= 32'b0;
            rdata_q    <= 32'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: byte-level reference model, per-cycle bus/completion checks,
// zero-wait and 3-cycle-delay memory, plus a second instance with misalignment disallowed.
module tb_load_store_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset, start, start_nm, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy_nm, done_nm, err_nm, mem_req_nm, mem_we_nm;
    logic [31:0] rdata_nm, mem_addr_nm, mem_wdata_nm, mem_rdata_nm;
    logic [3:0]  mem_be_nm;

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          ack_delay, wait_cnt = 0;
    logic        ack_force;

    // Reference model state
    acc_t        exp_acc[$];
    acc_t        obs[$];
    logic        exp_err, exp_store;
    logic [31:0] exp_rdata, model_rdata;
    bit          op_pending, run_chk, seen_req;
    int          acc_idx, start_cyc, last_ack_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'hF00FF00F;
            32'h104: return 32'h12345678;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = mem_word({ba[31:2], 2'b00});
        return w[8*ba[1:0] +: 8];
    endfunction

    // Read-only memory: stores are checked on the bus, not written back.
    always @(posedge clk) wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;
    assign mem_ack      = (mem_req && wait_cnt >= ack_delay) || ack_force;
    assign mem_rdata    = mem_word(mem_addr);
    assign mem_rdata_nm = mem_word(mem_addr_nm);

    load_store_ctrl #(.ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_ctrl #(.ALLOW_MISALIGN(1'b0)) dut_nm (
        .clk(clk), .reset(reset), .start(start_nm), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy_nm), .done(done_nm), .err(err_nm),
        .rdata(rdata_nm), .mem_req(mem_req_nm), .mem_we(mem_we_nm), .mem_addr(mem_addr_nm),
        .mem_be(mem_be_nm), .mem_wdata(mem_wdata_nm), .mem_ack(mem_req_nm),
        .mem_rdata(mem_rdata_nm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Walk the request byte by byte: each byte lands in word (a+k)&~3, lane (a+k)&3.
    task automatic plan(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit allow);
        int          sz, n, lane;
        logic [31:0] wa[2];
        logic [3:0]  be[2];
        logic [31:0] wv[2];
        logic [31:0] val, ba;
        bit          bad;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
        n   = 0;
        val = 32'h0;
        for (int i = 0; i < 2; i++) begin
            wa[i] = 32'h0; be[i] = 4'h0; wv[i] = 32'h0;
        end
        for (int k = 0; k < sz; k++) begin
            ba = a + 32'(k);
            if (n == 0) begin
                wa[0] = {ba[31:2], 2'b00}; n = 1;
            end else if (wa[n-1] != {ba[31:2], 2'b00}) begin
                wa[n] = {ba[31:2], 2'b00}; n++;
            end
            lane = int'(ba[1:0]);
            be[n-1][lane]        = 1'b1;
            wv[n-1][8*lane +: 8] = wd[8*k +: 8];
            val[8*k +: 8]        = mem_byte(ba);
        end
        if (!allow && n > 1) bad = 1'b1;
        exp_acc.delete();
        exp_store = st;
        exp_err   = bad;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                acc_t t;
                t.addr = wa[i]; t.be = be[i]; t.wdata = wv[i];
                exp_acc.push_back(t);
            end
        end
        if (bad)                exp_rdata = 32'h0;
        else if (st)            exp_rdata = model_rdata;
        else if (f3 == 3'b000)  exp_rdata = {{24{val[7]}}, val[7:0]};
        else if (f3 == 3'b001)  exp_rdata = {{16{val[15]}}, val[15:0]};
        else                    exp_rdata = val;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (run_chk) begin
            if (op_pending) begin
                if (cyc > start_cyc) check("busy_during_op", 32'(busy), 32'd1);
                if (seen_req && !done && acc_idx < exp_acc.size())
                    check("req_held", 32'(mem_req), 32'd1);
                if (mem_req) begin
                    if (!seen_req) begin
                        check("req_latency", cyc, start_cyc + 1);
                        seen_req = 1'b1;
                    end
                    if (acc_idx < exp_acc.size()) begin
                        check("acc_addr", mem_addr, exp_acc[acc_idx].addr);
                        check("acc_we", 32'(mem_we), 32'(exp_store));
                        if (exp_store) begin
                            check("acc_be", 32'(mem_be), 32'(exp_acc[acc_idx].be));
                            check("acc_wdata", mem_wdata, exp_acc[acc_idx].wdata);
                        end
                    end else begin
                        check("acc_count", 32'(acc_idx + 1), 32'(exp_acc.size()));
                    end
                    if (mem_ack) begin
                        acc_t t;
                        t.addr = mem_addr; t.be = mem_be; t.wdata = mem_wdata;
                        obs.push_back(t);
                        acc_idx++;
                        last_ack_cyc = cyc;
                    end
                end
                if (done) begin
                    check("done_err", 32'(err), 32'(exp_err));
                    check("done_rdata", rdata, exp_rdata);
                    check("done_accesses", 32'(acc_idx), 32'(exp_acc.size()));
                    check("done_latency", cyc,
                          (exp_acc.size() > 0) ? last_ack_cyc + 1 : start_cyc + 1);
                    model_rdata = exp_rdata;
                    op_pending  = 1'b0;
                end
            end else begin
                check("idle_quiet", 32'({busy, done, mem_req}), 32'd0);
                check("rdata_held", rdata, model_rdata);
            end
        end
    end

    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit poke);
        int waited;
        obs.delete();
        acc_idx  = 0;
        seen_req = 1'b0;
        @(posedge clk); #1;
        is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        start_cyc  = cyc;
        op_pending = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            // Second request while busy must be dropped, not queued
            @(posedge clk); #1;
            start = 1'b1; addr = a ^ 32'h4;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waited = 0;
        while (op_pending && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++;
        if (op_pending) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", waited);
            op_pending = 1'b0;
        end
    endtask

    logic [2:0]  ld_f3[8]   = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b010};
    logic [31:0] ld_addr[8] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h100,
                                32'h103, 32'h101};
    logic [31:0] ld_exp[8]  = '{32'h0000000F, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFFF00F,
                                32'h0000F00F, 32'hF00FF00F, 32'h000078F0, 32'h78F00FF0};
    int          ld_nacc[8] = '{1, 1, 1, 1, 1, 1, 2, 2};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, nm_req, nm_done, s;
        reset = 1'b1; start = 1'b0; start_nm = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; ack_delay = 0; ack_force = 1'b0;
        run_chk = 1'b0; op_pending = 1'b0; model_rdata = 32'h0;
        start_cyc = 0; last_ack_cyc = 0; acc_idx = 0; seen_req = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({busy, done, err, mem_req, mem_we, mem_be}), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_nm_ctrl", 32'({busy_nm, done_nm, err_nm, mem_req_nm, mem_we_nm, mem_be_nm}),
              32'd0);
        check("rst_nm_data", rdata_nm | mem_addr_nm | mem_wdata_nm, 32'h0);
        @(posedge clk); #1;
        reset   = 1'b0;
        run_chk = 1'b1;

        // Loads against zero-wait, then 3-cycle-delay memory
        for (int d = 0; d < 2; d++) begin
            ack_delay = (d == 0) ? 0 : 3;
            for (int v = 0; v < 8; v++) begin
                plan(1'b0, ld_f3[v], ld_addr[v], 32'h0, 1'b1);
                check("model_pin_load", exp_rdata, ld_exp[v]);
                run_op(1'b0, ld_f3[v], ld_addr[v], 32'h0, 1'b0);
                check("load_rdata", rdata, ld_exp[v]);
                check("load_accesses", 32'(obs.size()), 32'(ld_nacc[v]));
            end
        end

        // Split store, literal bus values
        ack_delay = 0;
        plan(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 1'b1);
        run_op(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 1'b0);
        check("sw_split_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            check("sw_acc0_addr", obs[0].addr, 32'h100);
            check("sw_acc0_be", 32'(obs[0].be), 32'hC);
            check("sw_acc0_wdata", obs[0].wdata, 32'hCCDD0000);
            check("sw_acc1_addr", obs[1].addr, 32'h104);
            check("sw_acc1_be", 32'(obs[1].be), 32'h3);
            check("sw_acc1_wdata", obs[1].wdata, 32'h0000AABB);
        end
        check("store_keeps_rdata", rdata, 32'h78F00FF0);

        // Byte/half stores, delayed memory
        ack_delay = 3;
        plan(1'b1, 3'b000, 32'h103, 32'h12345655, 1'b1);
        run_op(1'b1, 3'b000, 32'h103, 32'h12345655, 1'b0);
        plan(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 1'b1);
        run_op(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 1'b0);
        plan(1'b1, 3'b001, 32'h103, 32'h00001122, 1'b1);
        run_op(1'b1, 3'b001, 32'h103, 32'h00001122, 1'b0);
        check("sh_split_count", 32'(obs.size()), 32'd2);

        // Illegal requests
        ack_delay = 0;
        plan(1'b0, 3'b011, 32'h100, 32'h0, 1'b1);
        check("model_pin_illegal", 32'(exp_err), 32'd1);
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        check("illegal_no_access", 32'(obs.size()), 32'd0);
        check("illegal_rdata", rdata, 32'h0);
        plan(1'b1, 3'b100, 32'h100, 32'h55, 1'b1);
        run_op(1'b1, 3'b100, 32'h100, 32'h55, 1'b0);
        check("illegal_store_no_access", 32'(obs.size()), 32'd0);
        plan(1'b0, 3'b010, 32'h104, 32'h0, 1'b1);
        run_op(1'b0, 3'b010, 32'h104, 32'h0, 1'b0);
        check("lw_104", rdata, 32'h12345678);

        // Start while busy is ignored
        ack_delay = 3;
        plan(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
        check("poke_rdata", rdata, 32'hF00FF00F);
        check("poke_accesses", 32'(obs.size()), 32'd1);
        repeat (4) @(posedge clk);

        // Reset during second access of lw 0x101, then a late ack
        plan(1'b0, 3'b010, 32'h101, 32'h0, 1'b1);
        obs.delete(); acc_idx = 0; seen_req = 1'b0;
        @(posedge clk); #1;
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h101; start = 1'b1;
        start_cyc = cyc; op_pending = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        waited = 0;
        while (!(mem_req && mem_addr == 32'h104) && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_acc1", mem_addr, 32'h104);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; op_pending = 1'b0; model_rdata = 32'h0; ack_force = 1'b1;
        @(negedge clk);
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        ack_force = 1'b0;
        repeat (4) @(posedge clk);
        ack_delay = 0;
        plan(1'b0, 3'b000, 32'h100, 32'h0, 1'b1);
        run_op(1'b0, 3'b000, 32'h100, 32'h0, 1'b0);
        check("lb_after_reset", rdata, 32'h0000000F);

        // Misalignment disallowed: lw 0x102 errors with no memory access
        plan(1'b0, 3'b010, 32'h102, 32'h0, 1'b0);
        check("model_pin_nm_err", 32'(exp_err), 32'd1);
        @(posedge clk); #1;
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h102; start_nm = 1'b1; s = cyc;
        @(posedge clk); #1;
        start_nm = 1'b0;
        nm_req = 0; nm_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req_nm) nm_req++;
            if (done_nm) begin
                nm_done++;
                check("nm_err", 32'(err_nm), 32'd1);
                check("nm_rdata", rdata_nm, 32'h0);
                check("nm_latency", cyc, s + 1);
            end
        end
        check("nm_one_done", 32'(nm_done), 32'd1);
        check("nm_no_req", 32'(nm_req), 32'd0);

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter ALLOW_MISALIGN, default 1: 1 = misaligned accesses are split into two word transactions; 0 = misaligned accesses raise err with no memory access.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  core request; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 busy  out  1  high in every non-IDLE state.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  valid with done; illegal funct3 or disallowed misalign.
REQ-012 rdata  out  32  extended load result; valid with done, held until next accepted start.
REQ-013 mem_req  out  1  memory request valid.
REQ-014 mem_we  out  1  write enable.
REQ-015 mem_addr  out  32  word-aligned address, addr[1:0]=00.
REQ-016 mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-017 mem_wdata  out  32  lane-aligned store data.
REQ-018 mem_ack  in  1  memory completes the current request in this cycle.
REQ-019 mem_rdata  in  32  read word, valid when mem_ack=1.

Function
REQ-020 FSM states: IDLE, ACC0, ACC1, DONE.
REQ-021 IDLE + start: latch is_store, funct3, addr, wdata; go to ACC0; if the request is illegal (per REQ-027), go directly to DONE with err=1.
REQ-022 Size = 1/2/4 bytes from funct3[1:0]; off = addr[1:0]; split = (off + size > 4).
REQ-023 ACC0: mem_req=1, mem_addr={addr[31:2],2'b00}; mem_req, mem_addr, mem_be, mem_wdata and mem_we held stable until mem_ack=1.
REQ-024 ACC0 on mem_ack: capture mem_rdata as word0; go to ACC1 if split, else DONE.
REQ-025 ACC1: mem_addr = ACC0 address + 4; mem_req stays high with no idle cycle between accesses; on mem_ack, capture word1 and go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; mem_req=0.
REQ-027 funct3 in {011,110,111}, stores with funct3[2]=1, or split with ALLOW_MISALIGN=0 are illegal: err=1, rdata=0, mem_req never asserted.
REQ-028 Store lanes: the 64-bit value {32'b0,wdata} << 8*off, masked to size; ACC0 uses the low word with be = size-mask<<off (low 4 bits); ACC1 uses the high word with the overflowed mask bits.
REQ-029 Load: shift {word1,word0} right by 8*off, take the low size bytes; sign-extend for b/h and zero-extend for bu/hu; word1 = 0 when not split.
REQ-030 mem_we = is_store in ACC0/ACC1; for stores, rdata is unchanged.
REQ-031 start asserted while busy is ignored; it is not queued.
REQ-032 Aligned latency: start at cycle N -> mem_req from N+1 -> ack at cycle M -> done at M+1.

Reset
REQ-033 reset forces IDLE; busy, done, err, mem_req, mem_we = 0; mem_be = 0; rdata, mem_addr, mem_wdata = 0.
REQ-034 reset during ACC0/ACC1 abandons the transaction: mem_req=0 in the cycle after the reset edge, no done pulse, and any late mem_ack is ignored.

Verification
REQ-035 Memory holds 0x100=0xF00FF00F and 0x104=0x12345678; a zero-wait ack memory plus a 3-cycle-delay ack variant must both be run.
REQ-036 Loads: lb 0x100 -> 0x0000000F; lb 0x101 -> 0xFFFFFFF0; lbu 0x101 -> 0x000000F0; lh 0x102 -> 0xFFFFF00F; lhu 0x102 -> 0x0000F00F; lw 0x100 -> 0xF00FF00F; each takes a single access.
REQ-037 Split loads: lh 0x103 -> two accesses (0x100, 0x104), rdata=0x000078F0; lw 0x101 -> 0x78F00FF0.
REQ-038 Split store: sw 0x102 with wdata 0xAABBCCDD -> access 1: addr 0x100, be 1100, wdata 0xCCDD0000; access 2: addr 0x104, be 0011, wdata 0x0000AABB.
REQ-039 Illegal and disallowed cases: funct3=011 -> done with err=1, no mem_req; ALLOW_MISALIGN=0 with lw 0x102 -> err=1, no mem_req.
REQ-040 Reset during ACC1 of lw 0x101 -> mem_req=0 and busy=0 in the next cycle, no done pulse; a following lb 0x100 returns 0x0000000F.
